// File: rtl/evt2_stream_decoder.sv
// EVT2 front-end: decodes 32-bit EVT2 words into downsampled grid events with a
// windowed timestamp, applies an ROI offset with clamp-or-drop handling, and
// presents events through a 2-entry output buffer on a valid/ready stream.
// Build macro EVT2_DEC_STATS_EN adds saturating event/drop/unknown counters on
// stat_*; without it those ports are tied to zero.
module evt2_stream_decoder #(
   parameter int unsigned GRID_BITS  = 4,
   parameter int unsigned DS_SHIFT   = 4,
   parameter int unsigned X_OFFSET   = 0,
   parameter int unsigned Y_OFFSET   = 0,
   parameter int unsigned CLAMP_MODE = 1,
   parameter int unsigned TS_BITS    = 16,
   parameter int unsigned TS_LSB     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [GRID_BITS-1:0] x_out,
   output logic [GRID_BITS-1:0] y_out,
   output logic                 polarity,
   output logic [TS_BITS-1:0]   timestamp,
   output logic                 event_valid,
   input  logic                 event_ready,
   output logic [15:0]          stat_events,
   output logic [15:0]          stat_dropped,
   output logic [15:0]          stat_unknown
);

   localparam int unsigned RAW_BITS     = 11;
   localparam int unsigned REL_BITS     = 12;
   localparam int unsigned TH_BITS      = 28;
   localparam int unsigned TSL_BITS     = 6;
   localparam int unsigned FULL_TS_BITS = TH_BITS + TSL_BITS;
   localparam int unsigned CNT_BITS     = 16;

   localparam logic [RAW_BITS-1:0]        X_OFF    = RAW_BITS'(X_OFFSET);
   localparam logic [RAW_BITS-1:0]        Y_OFF    = RAW_BITS'(Y_OFFSET);
   localparam logic signed [REL_BITS-1:0] GRID_MAX = REL_BITS'((1 << GRID_BITS) - 1);

   localparam logic [3:0] PKT_CD_OFF    = 4'h0;
   localparam logic [3:0] PKT_CD_ON     = 4'h1;
   localparam logic [3:0] PKT_TIME_HIGH = 4'h8;
   localparam logic [3:0] PKT_EXT_A     = 4'hA;
   localparam logic [3:0] PKT_EXT_TRIG  = 4'hE;

   typedef struct packed {
      logic [GRID_BITS-1:0] x;
      logic [GRID_BITS-1:0] y;
      logic                 pol;
      logic [TS_BITS-1:0]   ts;
   } evt_t;

   // One axis: {in_range, clamped grid coordinate}
   function automatic logic [GRID_BITS:0] map_axis(input logic [RAW_BITS-1:0] raw,
                                                   input logic [RAW_BITS-1:0] off);
      logic signed [REL_BITS-1:0] rel;
      logic signed [REL_BITS-1:0] g;
      rel = $signed({1'b0, raw}) - $signed({1'b0, off});
      g   = rel >>> DS_SHIFT;
      if (g[REL_BITS-1])
         map_axis = {1'b0, {GRID_BITS{1'b0}}};
      else if (g > GRID_MAX)
         map_axis = {1'b0, {GRID_BITS{1'b1}}};
      else
         map_axis = {1'b1, GRID_BITS'(g)};
   endfunction

   logic [TH_BITS-1:0]      time_high_q;
   logic                    th_seen_q;
   logic [1:0]              count_q, count_d;
   evt_t                    head_q, head_d, tail_q, tail_d;
   evt_t                    evt_in;
   logic [GRID_BITS:0]      x_map, y_map;
   logic [FULL_TS_BITS-1:0] full_ts;
   logic [3:0]              pkt_type;
   logic                    accept, is_cd, is_th, coord_ok, push, pop;

   assign pkt_type = data_in[31:28];
   assign accept   = data_valid && data_ready;
   assign is_cd    = (pkt_type == PKT_CD_OFF) || (pkt_type == PKT_CD_ON);
   assign is_th    = (pkt_type == PKT_TIME_HIGH);
   assign pop      = event_valid && event_ready;
   assign push     = accept && is_cd && th_seen_q && coord_ok;

   // Decode the CD payload into a candidate buffer entry
   always_comb begin
      evt_in   = '0;
      x_map    = map_axis(data_in[21:11], X_OFF);
      y_map    = map_axis(data_in[10:0], Y_OFF);
      full_ts  = {time_high_q, data_in[27:22]};
      evt_in.x   = x_map[GRID_BITS-1:0];
      evt_in.y   = y_map[GRID_BITS-1:0];
      evt_in.pol = (pkt_type == PKT_CD_ON);
      evt_in.ts  = TS_BITS'(full_ts >> TS_LSB);
      coord_ok = (CLAMP_MODE != 0) || (x_map[GRID_BITS] && y_map[GRID_BITS]);
   end

   // Buffer next state: head is the presented entry, tail the queued one
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = evt_in;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = evt_in;
            end else if (push) begin
               tail_d  = evt_in;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   // Buffer state and registered handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
         event_valid <= 1'b0;
         data_ready  <= 1'b1;
      end else begin
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         event_valid <= (count_d != 2'd0);
         data_ready  <= (count_d != 2'd2);
      end
   end

   // TIME_HIGH capture; applies to CD words accepted afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_high_q <= '0;
         th_seen_q   <= 1'b0;
      end else if (accept && is_th) begin
         time_high_q <= data_in[TH_BITS-1:0];
         th_seen_q   <= 1'b1;
      end
   end

   assign x_out     = head_q.x;
   assign y_out     = head_q.y;
   assign polarity  = head_q.pol;
   assign timestamp = head_q.ts;

`ifdef EVT2_DEC_STATS_EN
   logic                cd_drop, unk_word;
   logic [CNT_BITS-1:0] events_q, dropped_q, unknown_q;

   assign cd_drop  = accept && is_cd && !push;
   assign unk_word = accept && !is_cd && !is_th &&
                     (pkt_type != PKT_EXT_A) && (pkt_type != PKT_EXT_TRIG);

   // Saturating statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         events_q  <= '0;
         dropped_q <= '0;
         unknown_q <= '0;
      end else begin
         if (push && (events_q != '1))
            events_q <= events_q + CNT_BITS'(1);
         if (cd_drop && (dropped_q != '1))
            dropped_q <= dropped_q + CNT_BITS'(1);
         if (unk_word && (unknown_q != '1))
            unknown_q <= unknown_q + CNT_BITS'(1);
      end
   end

   assign stat_events  = events_q;
   assign stat_dropped = dropped_q;
   assign stat_unknown = unknown_q;
`else
   assign stat_events  = 16'h0000;
   assign stat_dropped = 16'h0000;
   assign stat_unknown = 16'h0000;
`endif

endmodule
